// File: rtl/riscv_core_hazard_ctrl_t_if.sv
// Hazard-controller port bundle: pipeline status in, per-stage stall/clear requests out.
// master = pipeline side, slave = hazard controller.
interface riscv_core_hazard_ctrl_t_if #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
);
  logic [4:0]          id_rs1_idx;
  logic [4:0]          id_rs2_idx;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [4:0]          ex_rd_idx;
  logic                ex_is_load;
  logic                ex_mc_start;
  logic [MC_CNT_W-1:0] ex_mc_cycles;
  logic                ex_branch_taken;
  logic                me_mem_req;
  logic                me_mem_ready;
  logic                if_fetch_ready;
  logic                s_if_stall;
  logic                s_id_stall;
  logic                s_ex_stall;
  logic                s_me_stall;
  logic                s_wb_stall;
  logic                s_id_clear;
  logic                s_ex_clear;
  logic                s_me_clear;
  logic                s_wb_clear;
  logic                mc_busy;
  logic [PERF_W-1:0]   perf_stall_cycles;

  modport master (
    output id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, ex_rd_idx, ex_is_load,
           ex_mc_start, ex_mc_cycles, ex_branch_taken, me_mem_req, me_mem_ready, if_fetch_ready,
    input  s_if_stall, s_id_stall, s_ex_stall, s_me_stall, s_wb_stall,
           s_id_clear, s_ex_clear, s_me_clear, s_wb_clear, mc_busy, perf_stall_cycles
  );

  modport slave (
    input  id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, ex_rd_idx, ex_is_load,
           ex_mc_start, ex_mc_cycles, ex_branch_taken, me_mem_req, me_mem_ready, if_fetch_ready,
    output s_if_stall, s_id_stall, s_ex_stall, s_me_stall, s_wb_stall,
           s_id_clear, s_ex_clear, s_me_clear, s_wb_clear, mc_busy, perf_stall_cycles
  );
endinterface

// File: rtl/riscv_core_hazard_ctrl_t.sv
// Hazard/flush generator for the 5-stage core: fixed-priority stall/clear requests,
// multi-cycle EX sequencer and a saturating stall-cycle counter.
module riscv_core_hazard_ctrl_t #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  riscv_core_hazard_ctrl_t_if.slave  hz
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  logic [0:0]          state_r;
  logic [0:0]          state_nxt_s;
  logic [MC_CNT_W-1:0] mc_cnt_r;
  logic [MC_CNT_W-1:0] mc_cnt_nxt_s;
  logic [PERF_W-1:0]   perf_r;

  logic memw_s, mc_s, br_s, lu_s, fe_s;
  // stall_s[0]=IF .. stall_s[4]=WB ; clear_s[0]=ID .. clear_s[3]=WB
  logic [4:0] stall_s;
  logic [3:0] clear_s;

  // Raw hazard conditions
  always_comb begin
    memw_s = hz.me_mem_req & ~hz.me_mem_ready;
    mc_s   = (state_r == ST_MC_BUSY);
    br_s   = hz.ex_branch_taken & ~mc_s;
    lu_s   = hz.ex_is_load & (hz.ex_rd_idx != 5'd0) &
             ((hz.id_rs1_used & (hz.id_rs1_idx == hz.ex_rd_idx)) |
              (hz.id_rs2_used & (hz.id_rs2_idx == hz.ex_rd_idx)));
    fe_s   = ~hz.if_fetch_ready;
  end

  // Highest-priority hazard selects the stall/clear pattern; outputs forced low in reset
  always_comb begin
    stall_s = 5'b00000;
    clear_s = 4'b0000;
    if (!RST) begin
      stall_s = 5'b00000;
      clear_s = 4'b0000;
    end else if (memw_s) begin
      stall_s = 5'b01111;
      clear_s = 4'b1000;
    end else if (mc_s) begin
      stall_s = 5'b00111;
      clear_s = 4'b0100;
    end else if (br_s) begin
      stall_s = 5'b00000;
      clear_s = 4'b0011;
    end else if (lu_s) begin
      stall_s = 5'b00011;
      clear_s = 4'b0010;
    end else if (fe_s) begin
      stall_s = 5'b00001;
      clear_s = 4'b0001;
    end else begin
      stall_s = 5'b00000;
      clear_s = 4'b0000;
    end
  end

  // Multi-cycle sequencer next state; leaving on the last decrement gives exactly N held cycles
  always_comb begin
    state_nxt_s  = state_r;
    mc_cnt_nxt_s = mc_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (hz.ex_mc_start && (hz.ex_mc_cycles != {MC_CNT_W{1'b0}}) && !memw_s) begin
          state_nxt_s  = ST_MC_BUSY;
          mc_cnt_nxt_s = hz.ex_mc_cycles;
        end else begin
          state_nxt_s  = ST_RUN;
          mc_cnt_nxt_s = mc_cnt_r;
        end
      end
      ST_MC_BUSY: begin
        if (memw_s) begin
          state_nxt_s  = ST_MC_BUSY;
          mc_cnt_nxt_s = mc_cnt_r;
        end else if (mc_cnt_r <= {{(MC_CNT_W-1){1'b0}}, 1'b1}) begin
          state_nxt_s  = ST_RUN;
          mc_cnt_nxt_s = {MC_CNT_W{1'b0}};
        end else begin
          state_nxt_s  = ST_MC_BUSY;
          mc_cnt_nxt_s = mc_cnt_r - {{(MC_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        mc_cnt_nxt_s = {MC_CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_RUN;
      mc_cnt_r <= {MC_CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
    end
  end

  // Saturating count of IF-stall cycles
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_r <= {PERF_W{1'b0}};
    end else if (stall_s[0] && (perf_r != {PERF_W{1'b1}})) begin
      perf_r <= perf_r + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      perf_r <= perf_r;
    end
  end

  assign hz.s_if_stall        = stall_s[0];
  assign hz.s_id_stall        = stall_s[1];
  assign hz.s_ex_stall        = stall_s[2];
  assign hz.s_me_stall        = stall_s[3];
  assign hz.s_wb_stall        = stall_s[4];
  assign hz.s_id_clear        = clear_s[0];
  assign hz.s_ex_clear        = clear_s[1];
  assign hz.s_me_clear        = clear_s[2];
  assign hz.s_wb_clear        = clear_s[3];
  assign hz.mc_busy           = RST & (state_r == ST_MC_BUSY);
  assign hz.perf_stall_cycles = perf_r;

endmodule

// File: tb/tb_riscv_core_hazard_ctrl_t.sv
// Scoreboard bench for riscv_core_hazard_ctrl_t: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_riscv_core_hazard_ctrl_t;
  localparam int MCW = 6;
  localparam int PW  = 4;

  // Expected vector order: {if,id,ex,me,wb stall, id,ex,me,wb clear, mc_busy}
  localparam logic [9:0] E_NONE = 10'b00000_0000_0;
  localparam logic [9:0] E_MEMW = 10'b11110_0001_0;
  localparam logic [9:0] E_MEMB = 10'b11110_0001_1;
  localparam logic [9:0] E_MC   = 10'b11100_0010_1;
  localparam logic [9:0] E_BR   = 10'b00000_1100_0;
  localparam logic [9:0] E_LU   = 10'b11000_0100_0;
  localparam logic [9:0] E_FE   = 10'b10000_1000_0;

  typedef struct {
    logic [9:0]    vec;
    bit            chk_perf;
    logic [PW-1:0] perf;
    string         name;
  } exp_t;

  logic CLK;
  logic RST;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  riscv_core_hazard_ctrl_t_if #(.MC_CNT_W(MCW), .PERF_W(PW)) hz ();

  riscv_core_hazard_ctrl_t #(.MC_CNT_W(MCW), .PERF_W(PW)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = sb_q.pop_front();
      act = {hz.s_if_stall, hz.s_id_stall, hz.s_ex_stall, hz.s_me_stall, hz.s_wb_stall,
             hz.s_id_clear, hz.s_ex_clear, hz.s_me_clear, hz.s_wb_clear, hz.mc_busy};
      n_cmp++;
      if (act !== e.vec) begin
        n_err++;
        $display("FAIL %s: outputs got %b expected %b", e.name, act, e.vec);
      end
      if (e.chk_perf) begin
        n_cmp++;
        if (hz.perf_stall_cycles !== e.perf) begin
          n_err++;
          $display("FAIL %s_perf: perf got %0d expected %0d", e.name, hz.perf_stall_cycles, e.perf);
        end
      end
    end
  end

  task automatic idle();
    hz.id_rs1_idx = 5'd0; hz.id_rs2_idx = 5'd0;
    hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_rd_idx = 5'd0; hz.ex_is_load = 1'b0;
    hz.ex_mc_start = 1'b0; hz.ex_mc_cycles = 6'd0;
    hz.ex_branch_taken = 1'b0;
    hz.me_mem_req = 1'b0; hz.me_mem_ready = 1'b0;
    hz.if_fetch_ready = 1'b1;
  endtask

  // Push the expectation for the current input set, then advance to next posedge+1
  task automatic cyc(input logic [9:0] v, input string nm,
                     input bit cp = 1'b0, input logic [PW-1:0] p = 4'd0);
    exp_t e;
    e.vec = v; e.chk_perf = cp; e.perf = p; e.name = nm;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic mc_start(input logic [MCW-1:0] n);
    hz.ex_mc_start = 1'b1;
    hz.ex_mc_cycles = n;
  endtask

  initial begin
    idle();
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Reset masks live load-use and mem-wait hazards
    hz.ex_is_load = 1'b1; hz.ex_rd_idx = 5'd5;
    hz.id_rs1_idx = 5'd5; hz.id_rs1_used = 1'b1;
    hz.me_mem_req = 1'b1; hz.me_mem_ready = 1'b0;
    cyc(E_NONE, "rst_hold0", 1'b1, 4'd0);
    cyc(E_NONE, "rst_hold1", 1'b1, 4'd0);
    RST = 1'b1;
    cyc(E_MEMW, "rst_rel_memw");
    hz.me_mem_req = 1'b0;
    cyc(E_LU, "rst_rel_lu");

    // Load-use through rs2, rd==0 and unused operand
    idle();
    hz.ex_is_load = 1'b1; hz.ex_rd_idx = 5'd5;
    hz.id_rs1_idx = 5'd3; hz.id_rs1_used = 1'b1;
    hz.id_rs2_idx = 5'd5; hz.id_rs2_used = 1'b1;
    cyc(E_LU, "lu_rs2");
    hz.ex_rd_idx = 5'd0; hz.id_rs1_idx = 5'd0; hz.id_rs2_idx = 5'd0;
    cyc(E_NONE, "lu_rd0");
    hz.ex_rd_idx = 5'd5; hz.id_rs2_idx = 5'd5; hz.id_rs2_used = 1'b0;
    cyc(E_NONE, "lu_unused");

    // Multi-cycle op of 3 extra cycles; start held high while busy must be ignored
    idle();
    mc_start(6'd3);
    cyc(E_NONE, "mc3_start");
    cyc(E_MC, "mc3_b1");
    cyc(E_MC, "mc3_b2");
    cyc(E_MC, "mc3_b3");
    idle();
    cyc(E_NONE, "mc3_done");

    // Zero extra cycles: single-cycle op
    mc_start(6'd0);
    cyc(E_NONE, "mc0_start");
    idle();
    cyc(E_NONE, "mc0_after");

    // Mem wait inside MC_BUSY with counter=2 holds the counter
    mc_start(6'd3);
    cyc(E_NONE, "pri_start");
    idle();
    cyc(E_MC, "pri_mc_a");
    hz.me_mem_req = 1'b1;
    cyc(E_MEMB, "pri_memw1");
    cyc(E_MEMB, "pri_memw2");
    hz.me_mem_req = 1'b0;
    cyc(E_MC, "pri_mc_b");
    cyc(E_MC, "pri_mc_c");
    cyc(E_NONE, "pri_done");

    // Branch versus fetch and mem wait
    hz.ex_branch_taken = 1'b1; hz.if_fetch_ready = 1'b0;
    cyc(E_BR, "br_vs_fe");
    hz.if_fetch_ready = 1'b1; hz.me_mem_req = 1'b1;
    cyc(E_MEMW, "br_vs_memw");
    hz.me_mem_req = 1'b0;
    cyc(E_BR, "br_only");
    idle();
    hz.if_fetch_ready = 1'b0;
    cyc(E_FE, "fe_only");

    // Branch masked while busy, honoured once back in RUN
    idle();
    mc_start(6'd1);
    cyc(E_NONE, "brmc_start");
    idle();
    hz.ex_branch_taken = 1'b1;
    cyc(E_MC, "brmc_masked");
    cyc(E_BR, "brmc_run");

    // Asynchronous reset in the middle of MC_BUSY
    idle();
    mc_start(6'd5);
    cyc(E_NONE, "mcrst_start");
    idle();
    cyc(E_MC, "mcrst_busy");
    RST = 1'b0;
    cyc(E_NONE, "mcrst_in_rst", 1'b1, 4'd0);
    RST = 1'b1;
    cyc(E_NONE, "mcrst_after", 1'b1, 4'd0);

    // Fetch stall for 20 cycles saturates the 4-bit counter at 15
    hz.if_fetch_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(E_FE, $sformatf("perf_fe%0d", k), 1'b1, (k < 15) ? PW'(k) : 4'd15);
    end
    idle();
    cyc(E_NONE, "perf_hold", 1'b1, 4'd15);

    @(posedge CLK);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: pending %0d expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
